// File: rtl/arm7tdmi_burst_mem_responder_if.sv
// Burst read handshake between arm7tdmi_icache (master) and the memory
// responder (slave): request address/length in, beat data/valid/ready out.
interface arm7tdmi_burst_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic [2:0]            mem_burst_len;
  logic [31:0]           mem_data;
  logic                  mem_valid;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_req, mem_burst_len,
    input  mem_data, mem_valid, mem_ready
  );

  modport slave (
    input  mem_addr, mem_req, mem_burst_len,
    output mem_data, mem_valid, mem_ready
  );
endinterface

// File: rtl/arm7tdmi_burst_mem_responder.sv
// Line-fill burst responder: reads len+1 words from a sync SRAM after
// WAIT_STATES idle cycles and streams them to the icache, one per cycle.
// Ports: clk, rst_n (async, active-low); bus (slave modport: mem_addr,
// mem_req, mem_burst_len in; mem_data, mem_valid, mem_ready out);
// sram_addr/sram_rd_en out, sram_rdata in; busy and burst_count out.
module arm7tdmi_burst_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SRAM_AW     = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arm7tdmi_burst_mem_responder_if.slave bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic                 sram_rd_en,
  input  logic [31:0]          sram_rdata,
  output logic                 busy,
  output logic [31:0]          burst_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  localparam logic [3:0] WS_M1 =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [SRAM_AW-1:0] ONE =
    {{(SRAM_AW-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [3:0]         r_wcnt;
  logic [2:0]         r_len;
  logic [2:0]         r_idx;
  logic [SRAM_AW-1:0] r_base;
  logic               r_rd_pending;

  logic [SRAM_AW-1:0] w_base;
  logic               w_unused;

  assign w_base   = bus.mem_addr[SRAM_AW+1:2];
  assign w_unused = ^{bus.mem_addr[ADDR_WIDTH-1:SRAM_AW+2],
                      bus.mem_addr[1:0]};
  assign busy     = ~bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wcnt        <= 4'd0;
      r_len         <= 3'd0;
      r_idx         <= 3'd0;
      r_base        <= '0;
      r_rd_pending  <= 1'b0;
      sram_addr     <= '0;
      sram_rd_en    <= 1'b0;
      bus.mem_ready <= 1'b1;
      bus.mem_valid <= 1'b0;
      bus.mem_data  <= 32'd0;
      burst_count   <= 32'd0;
    end else begin
      // SRAM data arrives one cycle after the strobe is sampled.
      r_rd_pending <= sram_rd_en;
      if (r_rd_pending) begin
        bus.mem_valid <= 1'b1;
        bus.mem_data  <= sram_rdata;
      end else begin
        bus.mem_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.mem_req) begin
            r_len         <= bus.mem_burst_len;
            r_base        <= w_base;
            bus.mem_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state    <= S_READ;
              r_idx      <= 3'd0;
              sram_rd_en <= 1'b1;
              sram_addr  <= w_base;
            end else begin
              r_state <= S_WAIT;
              r_wcnt  <= WS_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state    <= S_READ;
            r_idx      <= 3'd0;
            sram_rd_en <= 1'b1;
            sram_addr  <= r_base;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_READ: begin
          if (r_idx == r_len) begin
            r_state    <= S_DRAIN;
            sram_rd_en <= 1'b0;
          end else begin
            r_idx     <= r_idx + 3'd1;
            // Wraps from the top SRAM word back to word 0.
            sram_addr <= sram_addr + ONE;
          end
        end
        S_DRAIN: begin
          // The pending read here is always the final beat.
          if (r_rd_pending) begin
            r_state       <= S_IDLE;
            bus.mem_ready <= 1'b1;
            if (burst_count != 32'hFFFF_FFFF)
              burst_count <= burst_count + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm7tdmi_burst_mem_responder.sv
// Self-checking bench for arm7tdmi_burst_mem_responder: burst vector table,
// beat scoreboard with cycle-exact timing, back-to-back and reset cases.
module tb_arm7tdmi_burst_mem_responder;

  localparam int WS = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] sram_addr;
  logic        sram_rd_en;
  logic [31:0] sram_rdata;
  logic        busy;
  logic [31:0] burst_count;

  arm7tdmi_burst_mem_responder_if #(.ADDR_WIDTH(32)) bus ();

  arm7tdmi_burst_mem_responder #(
    .ADDR_WIDTH (32),
    .SRAM_AW    (16),
    .WAIT_STATES(WS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .sram_addr  (sram_addr),
    .sram_rd_en (sram_rd_en),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .burst_count(burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD0000 + i;

  always @(posedge clk)
    if (sram_rd_en) sram_rdata <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          first;
    bit          last;
  } beat_t;

  beat_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int beats_seen = 0;
  int rd_cnt = 0;
  int last_beat_cyc = 0;
  int last_acc = 0;
  int exp_bc = 0;
  logic [31:0] obs_first;
  logic [31:0] obs_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sram_rd_en) rd_cnt++;
    if (rst_n && bus.mem_valid) begin
      beat_t e;
      beats_seen++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %h expected none (cycle %0d)",
                 bus.mem_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("beat_data", bus.mem_data, e.data);
        chk("beat_cycle", cyc, e.cyc);
        chk("ready_with_beat", {31'd0, bus.mem_ready}, {31'd0, e.last});
        if (e.first) obs_first = bus.mem_data;
        if (e.last) begin
          obs_last = bus.mem_data;
          last_beat_cyc = cyc;
        end
      end
    end
  end

  // Call at a negedge where mem_ready=1 with mem_req high: the next
  // posedge accepts the request.
  task automatic accept_now(input logic [31:0] a, input logic [2:0] l,
                            input bit hold);
    int acc;
    logic [15:0] w;
    bus.mem_req       = 1'b1;
    bus.mem_addr      = a;
    bus.mem_burst_len = l;
    acc = cyc + 1;
    last_acc = acc;
    for (int i = 0; i <= int'(l); i++) begin
      beat_t e;
      w = a[17:2] + 16'(i);
      e.data  = 32'hDEAD0000 + {16'd0, w};
      e.cyc   = acc + 2 + WS + i;
      e.first = (i == 0);
      e.last  = (i == int'(l));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("ready_low_after_accept", {31'd0, bus.mem_ready}, 32'd0);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (!hold) bus.mem_req = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] l,
                      input bit hold);
    int n = 0;
    @(negedge clk);
    bus.mem_req       = 1'b1;
    bus.mem_addr      = a;
    bus.mem_burst_len = l;
    while (!bus.mem_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_ready) begin
      $display("FAIL send_timeout: got ready=0 expected ready=1");
      n_err++;
      n_cmp++;
      bus.mem_req = 1'b0;
    end else begin
      accept_now(a, l, hold);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d beats left expected 0",
               sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int bs0;
    int n;

    vecs[0] = '{32'h0000_1000, 3'd7, 32'hDEAD0400, 32'hDEAD0407};
    vecs[1] = '{32'h0000_2006, 3'd0, 32'hDEAD0801, 32'hDEAD0801};
    vecs[2] = '{32'h0003_FFF8, 3'd3, 32'hDEADFFFE, 32'hDEAD0001};
    vecs[3] = '{32'h0000_0000, 3'd2, 32'hDEAD0000, 32'hDEAD0002};
    vecs[4] = '{32'hFFFF_FFFC, 3'd1, 32'hDEADFFFF, 32'hDEAD0000};

    bus.mem_req       = 1'b0;
    bus.mem_addr      = 32'd0;
    bus.mem_burst_len = 3'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("rst_count", burst_count, 32'd0);
    chk("rst_data", bus.mem_data, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      rd0 = rd_cnt;
      send(vecs[k].addr, vecs[k].len, 1'b0);
      drain();
      exp_bc++;
      chk("vec_first", obs_first, vecs[k].first);
      chk("vec_last", obs_last, vecs[k].last);
      chk("vec_count", burst_count, exp_bc);
      chk("vec_rd_pulses", rd_cnt - rd0, int'(vecs[k].len) + 1);
      chk("vec_ready_idle", {31'd0, bus.mem_ready}, 32'd1);
    end

    // mem_req held high, address scrambled mid-burst, back-to-back accept.
    rd0 = rd_cnt;
    send(32'h0000_4000, 3'd7, 1'b1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.mem_ready) break;
      bus.mem_addr      = $urandom;
      bus.mem_burst_len = 3'($urandom);
      n++;
    end
    accept_now(32'h0000_5004, 3'd3, 1'b0);
    chk("b2b_accept_edge", last_acc, last_beat_cyc + 1);
    drain();
    exp_bc += 2;
    chk("b2b_last", obs_last, 32'hDEAD1404);
    chk("b2b_count", burst_count, exp_bc);
    chk("b2b_rd_pulses", rd_cnt - rd0, 12);

    // Reset during the 3rd beat of an 8-beat burst.
    bs0 = beats_seen;
    send(32'h0000_1000, 3'd7, 1'b0);
    n = 0;
    while (beats_seen < bs0 + 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_mid_reached", beats_seen - bs0, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, bus.mem_ready}, 32'd1);
    chk("rst_mid_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("rst_mid_count", burst_count, 32'd0);
    sb.delete();
    exp_bc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bs0 = beats_seen;
    repeat (12) @(negedge clk);
    #1;
    chk("rst_no_more_beats", beats_seen - bs0, 0);
    send(32'h0000_1000, 3'd7, 1'b0);
    drain();
    exp_bc++;
    chk("rst_after_first", obs_first, 32'hDEAD0400);
    chk("rst_after_last", obs_last, 32'hDEAD0407);
    chk("rst_after_count", burst_count, exp_bc);
    chk("rst_after_beats", beats_seen - bs0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
